// File: rtl/datapath_ctrl_fsm_if.sv
// Control/instruction bundle between the datapath sequencer (slave) and the
// CPU or testbench that feeds it instructions and consumes its controls (master).
interface datapath_ctrl_fsm_if;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic        w;
   logic [1:0]  vsel;
   logic [2:0]  writenum;
   logic        write;
   logic [2:0]  readnum;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic        loadc;
   logic        loads;
   logic [1:0]  ALUop;
   logic [1:0]  shift;
   logic [15:0] sximm5;
   logic [15:0] sximm8;
   logic        illegal;

   modport master (
      output in, load, s,
      input  w, vsel, writenum, write, readnum, loada, loadb, asel, bsel,
             loadc, loads, ALUop, shift, sximm5, sximm8, illegal
   );

   modport slave (
      input  in, load, s,
      output w, vsel, writenum, write, readnum, loada, loadb, asel, bsel,
             loadc, loads, ALUop, shift, sximm5, sximm8, illegal
   );
endinterface

// File: rtl/datapath_ctrl_fsm.sv
// Instruction register, decoder and Moore sequencer for the lab datapath.
// Define CPU_ILLEGAL_HALT_EN to trap illegal opcodes in a HALT state.
module datapath_ctrl_fsm (
   input  logic                 clk,
   input  logic                 reset_n,
   datapath_ctrl_fsm_if.slave   bus
);

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_WRITE_IMM = 3'd2,
      S_GET_A     = 3'd3,
      S_GET_B     = 3'd4,
      S_ALU       = 3'd5,
      S_WRITE_REG = 3'd6
`ifdef CPU_ILLEGAL_HALT_EN
      , S_HALT    = 3'd7
`endif
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [15:0] ir_reg;

   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  rn;
   logic [2:0]  rd;
   logic [2:0]  rm;
   logic        is_mov_imm;
   logic        is_mov_reg;
   logic        is_alu;
   logic        is_mvn;
   logic        is_cmp;

   assign opcode = ir_reg[15:13];
   assign op     = ir_reg[12:11];
   assign rn     = ir_reg[10:8];
   assign rd     = ir_reg[7:5];
   assign rm     = ir_reg[2:0];

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_mvn     = is_alu && (op == 2'b11);
   assign is_cmp     = is_alu && (op == 2'b01);

   assign bus.shift  = ir_reg[4:3];
   assign bus.sximm5 = {{11{ir_reg[4]}}, ir_reg[4:0]};
   assign bus.sximm8 = {{8{ir_reg[7]}}, ir_reg[7:0]};

`ifdef CPU_ILLEGAL_HALT_EN
   // HALT is only left through reset, so the flag is sticky by construction.
   assign bus.illegal = (state_reg == S_HALT);
`else
   assign bus.illegal = 1'b0;
`endif

   // IR only follows the bus while idle, so a busy instruction is never disturbed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_reg <= 16'h0000;
      end else if ((state_reg == S_WAIT) && bus.load) begin
         ir_reg <= bus.in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_WAIT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_WAIT: begin
            if (bus.s) state_next = S_DECODE;
         end
         S_DECODE: begin
            if (is_mov_imm)                state_next = S_WRITE_IMM;
            else if (is_mov_reg || is_mvn) state_next = S_GET_B;
            else if (is_alu)               state_next = S_GET_A;
`ifdef CPU_ILLEGAL_HALT_EN
            else                           state_next = S_HALT;
`else
            else                           state_next = S_WAIT;
`endif
         end
         S_WRITE_IMM: state_next = S_WAIT;
         S_GET_A:     state_next = S_GET_B;
         S_GET_B:     state_next = S_ALU;
         S_ALU:       state_next = is_cmp ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: state_next = S_WAIT;
`ifdef CPU_ILLEGAL_HALT_EN
         S_HALT:      state_next = S_HALT;
`endif
         default:     state_next = S_WAIT;
      endcase
   end

   always_comb begin
      bus.w        = 1'b0;
      bus.vsel     = 2'b00;
      bus.writenum = 3'd0;
      bus.write    = 1'b0;
      bus.readnum  = 3'd0;
      bus.loada    = 1'b0;
      bus.loadb    = 1'b0;
      bus.asel     = 1'b0;
      bus.bsel     = 1'b0;
      bus.loadc    = 1'b0;
      bus.loads    = 1'b0;
      bus.ALUop    = 2'b00;
      case (state_reg)
         S_WAIT: bus.w = 1'b1;
         S_WRITE_IMM: begin
            bus.vsel     = 2'b10;
            bus.writenum = rn;
            bus.write    = 1'b1;
         end
         S_GET_A: begin
            bus.readnum = rn;
            bus.loada   = 1'b1;
         end
         S_GET_B: begin
            bus.readnum = rm;
            bus.loadb   = 1'b1;
         end
         S_ALU: begin
            // MOV reg encodes op=00, so passing op through yields ADD of 0 + B.
            bus.ALUop = op;
            bus.asel  = is_mov_reg || is_mvn;
            if (is_cmp) bus.loads = 1'b1;
            else        bus.loadc = 1'b1;
         end
         S_WRITE_REG: begin
            bus.vsel     = 2'b11;
            bus.writenum = rd;
            bus.write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
// Randomized self-checking bench: each instruction is expanded into its
// expected per-cycle control trace from the instruction-class rules.
module tb_datapath_ctrl_fsm;

   logic clk;
   logic reset_n;
   int   tests_run;
   int   tests_failed;

   datapath_ctrl_fsm_if bus ();

   datapath_ctrl_fsm dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {w, vsel, writenum, write, readnum, loada, loadb, asel, bsel, loadc, loads, ALUop}
   wire [17:0] ctl_obs = {bus.w, bus.vsel, bus.writenum, bus.write, bus.readnum,
                          bus.loada, bus.loadb, bus.asel, bus.bsel, bus.loadc,
                          bus.loads, bus.ALUop};

   logic [17:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      if (obs !== expv) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [17:0] mk(input logic w, input logic [1:0] vsel,
                                      input logic [2:0] wn, input logic wr,
                                      input logic [2:0] rdn, input logic la,
                                      input logic lb, input logic as,
                                      input logic bs, input logic lc,
                                      input logic ls, input logic [1:0] aop);
      return {w, vsel, wn, wr, rdn, la, lb, as, bs, lc, ls, aop};
   endfunction

   function automatic logic [15:0] sx8(input logic [15:0] i);
      return {{8{i[7]}}, i[7:0]};
   endfunction

   function automatic logic [15:0] sx5(input logic [15:0] i);
      return {{11{i[4]}}, i[4:0]};
   endfunction

   // Expected control trace for the cycles following the s-accepting edge.
   task automatic build_exp(input logic [15:0] i);
      logic [2:0] opc;
      logic [1:0] op;
      opc = i[15:13];
      op  = i[12:11];
      exp_q.delete();
      exp_q.push_back(18'd0);
      if (opc == 3'b110 && op == 2'b10) begin
         exp_q.push_back(mk(0, 2'b10, i[10:8], 1, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00));
      end else if ((opc == 3'b110 && op == 2'b00) || (opc == 3'b101 && op == 2'b11)) begin
         exp_q.push_back(mk(0, 2'b00, 3'd0, 0, i[2:0], 0, 1, 0, 0, 0, 0, 2'b00));
         exp_q.push_back(mk(0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 1, 0, 1, 0, op));
         exp_q.push_back(mk(0, 2'b11, i[7:5], 1, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00));
      end else if (opc == 3'b101) begin
         exp_q.push_back(mk(0, 2'b00, 3'd0, 0, i[10:8], 1, 0, 0, 0, 0, 0, 2'b00));
         exp_q.push_back(mk(0, 2'b00, 3'd0, 0, i[2:0], 0, 1, 0, 0, 0, 0, 2'b00));
         if (op == 2'b01) begin
            exp_q.push_back(mk(0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 1, op));
         end else begin
            exp_q.push_back(mk(0, 2'b00, 3'd0, 0, 3'd0, 0, 0, 0, 0, 1, 0, op));
            exp_q.push_back(mk(0, 2'b11, i[7:5], 1, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00));
         end
      end
      exp_q.push_back(mk(1, 2'b00, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00));
   endtask

   task automatic run_instr(input logic [15:0] instr, input bit noise);
      int n;
      build_exp(instr);
      n = exp_q.size();
      @(negedge clk);
      bus.in   = instr;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      bus.s    = 1'b0;
      for (int k = 0; k < n; k++) begin
         check($sformatf("ctl[%0d] %h", k, instr), {14'd0, ctl_obs}, {14'd0, exp_q[k]});
         if (noise && k == 0 && n > 2) begin
            bus.in   = 16'hD0FF;
            bus.load = 1'b1;
            bus.s    = 1'b1;
         end else begin
            bus.load = 1'b0;
            bus.s    = 1'b0;
         end
         if (k < n - 1) begin
            @(posedge clk);
            #1;
         end
      end
      check("ir_sximm8", {16'd0, bus.sximm8}, {16'd0, sx8(instr)});
      check("ir_sximm5", {16'd0, bus.sximm5}, {16'd0, sx5(instr)});
      check("ir_shift",  {30'd0, bus.shift},  {30'd0, instr[4:3]});
      check("illegal_clear", {31'd0, bus.illegal}, 32'd0);
      $display("[TB] instr=%h noise=%0d edges=%0d", instr, noise, n);
   endtask

   function automatic logic [15:0] rand_instr(input bit allow_illegal);
      logic [15:0] r;
      int          cls;
      r   = 16'($urandom);
      cls = allow_illegal ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 4));
      case (cls)
         0: r[15:11] = 5'b110_10;
         1: r[15:11] = 5'b110_00;
         2, 3, 4: r[15:13] = 3'b101;
         default: begin
            while (r[15:13] == 3'b101 || (r[15:13] == 3'b110 && r[11] == 1'b0))
               r = 16'($urandom);
         end
      endcase
      return r;
   endfunction

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      bus.in   = 16'h0000;
      bus.load = 1'b0;
      bus.s    = 1'b0;
      reset_n  = 1'b0;
      #12;
      check("reset_ctl", {14'd0, ctl_obs},
            {14'd0, mk(1, 2'b00, 3'd0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00)});
      check("reset_ir", {16'd0, bus.sximm8}, 32'd0);
      check("reset_illegal", {31'd0, bus.illegal}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      run_instr(16'hD007, 1'b0);
      run_instr(16'hD1FE, 1'b0);
      run_instr(16'hA148, 1'b0);
      run_instr(16'hA801, 1'b1);
      run_instr(16'hC0E9, 1'b0);
      run_instr(16'hB9A2, 1'b1);

      // Asynchronous reset part-way through an ADD.
      @(negedge clk);
      bus.in   = 16'hA148;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      bus.s    = 1'b0;
      @(posedge clk);
      #1;
      check("mid_get_a_loada", {31'd0, bus.loada}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_rst_w", {31'd0, bus.w}, 32'd1);
      check("async_rst_loada", {31'd0, bus.loada}, 32'd0);
      check("async_rst_write", {31'd0, bus.write}, 32'd0);
      check("async_rst_ir", {16'd0, bus.sximm8}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

`ifndef CPU_ILLEGAL_HALT_EN
      run_instr(16'h0000, 1'b0);
      run_instr(16'hE000, 1'b0);
`endif

      for (int t = 0; t < 40; t++) begin
`ifdef CPU_ILLEGAL_HALT_EN
         run_instr(rand_instr(1'b0), 1'($urandom_range(0, 1)));
`else
         run_instr(rand_instr(1'b1), 1'($urandom_range(0, 1)));
`endif
      end

`ifdef CPU_ILLEGAL_HALT_EN
      @(negedge clk);
      bus.in   = 16'hE000;
      bus.load = 1'b1;
      bus.s    = 1'b1;
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      bus.s    = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check("halt_w", {31'd0, bus.w}, 32'd0);
         check("halt_illegal", {31'd0, bus.illegal}, 32'd1);
         check("halt_write", {31'd0, bus.write}, 32'd0);
      end
      reset_n = 1'b0;
      #1;
      check("halt_rst_w", {31'd0, bus.w}, 32'd1);
      check("halt_rst_illegal", {31'd0, bus.illegal}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      $display("[TB] instr=e000 halted until reset");
      run_instr(16'hD007, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/datapath_ctrl_fsm.md
Name: datapath_ctrl_fsm

Overview:
Instruction register, decoder and Moore sequencing FSM for the lab datapath (regfile + shifter + ALU + A/B/C/status registers). Latches a 16-bit instruction, decodes MOV-immediate, MOV-register and ALU ops (ADD/CMP/AND/MVN), and drives every datapath control one state per clock. `w` signals idle/ready to the surrounding CPU/testbench.

Parameters:
none (instruction width fixed at 16)

Ports:
clk        in   1   rising-edge clock
reset_n    in   1   asynchronous active-low reset
in         in   16  instruction word
load       in   1   capture `in` into IR (honoured only while w=1)
s          in   1   start execution of IR (sampled only while w=1)
w          out  1   1 = idle in WAIT, ready for load/s
vsel       out  2   regfile write mux: 11=C, 10=sximm8, 01={8'b0,PC}, 00=mdata
writenum   out  3   regfile write address
write      out  1   regfile write enable
readnum    out  3   regfile read address
loada      out  1   A register load
loadb      out  1   B register load
asel       out  1   1 = ALU A input forced to 0
bsel       out  1   1 = ALU B input is sximm5
loadc      out  1   C register load
loads      out  1   status (Z,N,O) load
ALUop      out  2   00 ADD, 01 SUB/CMP, 10 AND, 11 NOT-B
shift      out  2   shifter op = IR[4:3]
sximm5     out  16  sign-extended IR[4:0]
sximm8     out  16  sign-extended IR[7:0]
illegal    out  1   sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Decoding: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], shift=IR[4:3], Rm=IR[2:0]. `sximm5`, `sximm8` and `shift` are continuous decodes of IR.
- Legal instructions: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/xx ALU with ALUop=op. Everything else is illegal.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, WRITE_REG (plus HALT when the macro is defined). Outputs are Moore, decoded from state and IR. Any control not listed for a state is 0, and vsel=00.
- WAIT: w=1. load=1 captures IR at the clock edge. If s=1, go to DECODE. If load and s are both 1 on the same edge, the new IR is captured and executed.
- Outside WAIT: load and s are ignored, IR is held, and w=0.
- DECODE routing:
  - MOV imm → WRITE_IMM.
  - MOV reg and MVN → GET_B.
  - ADD/CMP/AND → GET_A.
  - Illegal → WAIT (or HALT with the macro).
- WRITE_IMM: vsel=10, writenum=Rn, write=1 → WAIT.
- GET_A: readnum=Rn, loada=1 → GET_B.
- GET_B: readnum=Rm, loadb=1 → ALU.
- ALU: bsel=0, ALUop=op. For MOV reg and MVN, asel=1 and ALUop=00 for MOV reg. CMP asserts loads=1, loadc=0 → WAIT. All other ops assert loadc=1 → WRITE_REG.
- WRITE_REG: vsel=11, writenum=Rd, write=1 → WAIT.
- Latency, counted as edges from the s-accepting edge to w=1: MOV imm 3, MOV reg/MVN 5, CMP 5, ADD/AND 6.
- At most one of write, loada, loadb, loadc, loads is asserted per cycle.
- Reset (any state, asynchronous): state=WAIT, IR=0, illegal=0.
  - Outputs immediately: w=1, all enables 0, vsel=00.
  - An instruction in progress is abandoned and no further write is issued.

Optional Feature:
Macro CPU_ILLEGAL_HALT_EN.
- Defined: an illegal opcode in DECODE goes to HALT. HALT sets w=0 and illegal=1, drives all enables 0, and is left only by reset_n=0.
- Undefined: an illegal opcode returns to WAIT after DECODE, with no datapath side effects; illegal is tied to 0.

Test Plan:
- Reset: reset_n=0 mid-GET_A of 0xA148 → same cycle w=1, loada=0, write=0. After release, s with IR=0 (opcode 000, illegal) returns to WAIT with no write.
- MOV R0,#7: load 0xD007, s=1 → edge 2 cycle shows write=1, writenum=0, vsel=10, sximm8=0x0007; w=1 three edges after s.
- MOV R1,#-2: 0xD1FE → sximm8=0xFFFE, writenum=1.
- ADD R2,R1,R0,LSL#1: 0xA148 → readnum=1 with loada, then readnum=0 with loadb, shift=01, ALUop=00, loadc, then write=1, writenum=2, vsel=11; w=1 six edges after s.
- CMP R0,R1: 0xA801 → loads=1 in the ALU state, loadc=0, write never asserted; w=1 after 5 edges. Pulsing load=1 with 0xD0FF while busy leaves IR at 0xA801.
- Illegal 0xE000: without the macro, w returns after 2 edges and illegal=0. With CPU_ILLEGAL_HALT_EN, w stays 0 and illegal=1 until reset_n pulses low.
